// File: rtl/wb_dual_port_mem.sv
// wb_dual_port_mem: dual-port Wishbone classic slave memory.
// Port I is read-only and port D is read/write; both ports share one word array.
// Each port has programmable wait states, handles aborts, and writes byte lanes on port D.
// Define WB_MEM_ERR_EN to return err for out-of-range addresses and for sel=0 writes.
module wb_dual_port_mem #(
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          I_WAIT       = 0,
    parameter int          D_WAIT       = 0,
    parameter logic [31:0] I_RESET_DATA = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] iwb_adr_i,
    input  logic        iwb_cyc_i,
    input  logic        iwb_stb_i,
    output logic [31:0] iwb_dat_o,
    output logic        iwb_ack_o,
    output logic        iwb_err_o,
    input  logic [31:0] dwb_adr_i,
    input  logic [31:0] dwb_dat_i,
    input  logic [3:0]  dwb_sel_i,
    input  logic        dwb_we_i,
    input  logic        dwb_cyc_i,
    input  logic        dwb_stb_i,
    output logic [31:0] dwb_dat_o,
    output logic        dwb_ack_o,
    output logic        dwb_err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
`ifdef WB_MEM_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [31:0]   mem [DEPTH_WORDS];
    state_t        i_state, d_state;
    logic [3:0]    i_cnt, d_cnt;
    logic [AW-1:0] i_idx_q, d_idx_q, i_idx, d_idx;
    logic          i_err_q, d_err_q, d_we_q;
    logic [3:0]    d_sel_q, d_sel;
    logic [31:0]   d_dat_q, d_wdat;
    logic          i_req, d_req, i_go, d_go, i_bad, d_bad, d_we, d_wr;
    logic          unused_adr_bits;

    assign unused_adr_bits = &{1'b0, iwb_adr_i[1:0], dwb_adr_i[1:0]};

    // With zero wait states the access happens on the sampling edge, so use the live bus; otherwise the latched request
    assign i_req  = iwb_cyc_i & iwb_stb_i;
    assign d_req  = dwb_cyc_i & dwb_stb_i;
    assign i_go   = (i_state == IDLE && i_req && I_WAIT == 0) || (i_state == WAIT && iwb_cyc_i && i_cnt == 4'd1);
    assign d_go   = (d_state == IDLE && d_req && D_WAIT == 0) || (d_state == WAIT && dwb_cyc_i && d_cnt == 4'd1);
    assign i_idx  = i_state == IDLE ? iwb_adr_i[AW+1:2] : i_idx_q;
    assign d_idx  = d_state == IDLE ? dwb_adr_i[AW+1:2] : d_idx_q;
    assign d_we   = d_state == IDLE ? dwb_we_i : d_we_q;
    assign d_sel  = d_state == IDLE ? dwb_sel_i : d_sel_q;
    assign d_wdat = d_state == IDLE ? dwb_dat_i : d_dat_q;
    assign i_bad  = ERR_EN & (i_state == IDLE ? |(iwb_adr_i >> (AW + 2)) : i_err_q);
    assign d_bad  = ERR_EN & (d_state == IDLE ? (|(dwb_adr_i >> (AW + 2)) | (dwb_we_i & ~|dwb_sel_i)) : d_err_q);
    assign d_wr   = d_go & d_we & ~d_bad;

    // Byte-lane write on the edge entering RESP; a reset on that edge drops the write
    always_ff @(posedge clk) begin
        if (rst_n && d_wr)
            for (int b = 0; b < 4; b++)
                if (d_sel[b]) mem[d_idx][8*b +: 8] <= d_wdat[8*b +: 8];
    end

    // Port I FSM: latch in IDLE, count down in WAIT, one-cycle ack/err in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_state   <= IDLE;
            i_cnt     <= '0;
            i_idx_q   <= '0;
            i_err_q   <= 1'b0;
            iwb_ack_o <= 1'b0;
            iwb_err_o <= 1'b0;
            iwb_dat_o <= I_RESET_DATA;
        end else begin
            iwb_ack_o <= i_go & ~i_bad;
            iwb_err_o <= i_go & i_bad;
            if (i_go && !i_bad) iwb_dat_o <= mem[i_idx];
            case (i_state)
                IDLE: if (i_req) begin
                    i_idx_q <= i_idx;
                    i_err_q <= i_bad;
                    i_cnt   <= 4'(I_WAIT);
                    i_state <= I_WAIT == 0 ? RESP : WAIT;
                end
                WAIT: if (!iwb_cyc_i) i_state <= IDLE;
                      else if (i_cnt == 4'd1) i_state <= RESP;
                      else i_cnt <= i_cnt - 4'd1;
                default: i_state <= IDLE;
            endcase
        end
    end

    // Port D FSM: same timing as port I; read data on a write is the pre-write word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_state   <= IDLE;
            d_cnt     <= '0;
            d_idx_q   <= '0;
            d_err_q   <= 1'b0;
            d_we_q    <= 1'b0;
            d_sel_q   <= '0;
            d_dat_q   <= '0;
            dwb_ack_o <= 1'b0;
            dwb_err_o <= 1'b0;
            dwb_dat_o <= '0;
        end else begin
            dwb_ack_o <= d_go & ~d_bad;
            dwb_err_o <= d_go & d_bad;
            if (d_go && !d_bad) dwb_dat_o <= mem[d_idx];
            case (d_state)
                IDLE: if (d_req) begin
                    d_idx_q <= d_idx;
                    d_err_q <= d_bad;
                    d_we_q  <= dwb_we_i;
                    d_sel_q <= dwb_sel_i;
                    d_dat_q <= dwb_dat_i;
                    d_cnt   <= 4'(D_WAIT);
                    d_state <= D_WAIT == 0 ? RESP : WAIT;
                end
                WAIT: if (!dwb_cyc_i) d_state <= IDLE;
                      else if (d_cnt == 4'd1) d_state <= RESP;
                      else d_cnt <= d_cnt - 4'd1;
                default: d_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_dual_port_mem.sv
// tb_wb_dual_port_mem: directed vectors for wb_dual_port_mem; dut 0 has no wait states, dut 1 has I_WAIT=2 and D_WAIT=3.
module tb_wb_dual_port_mem;
`ifdef WB_MEM_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] iadr[2], idat[2], dadr[2], ddi[2], ddo[2];
    logic [3:0]  dsel[2];
    logic        icyc[2], istb[2], iack[2], ierr[2], dwe[2], dcyc[2], dstb[2], dack[2], derr[2];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    wb_dual_port_mem #(.DEPTH_WORDS(1024), .I_WAIT(0), .D_WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .iwb_adr_i(iadr[0]), .iwb_cyc_i(icyc[0]), .iwb_stb_i(istb[0]),
        .iwb_dat_o(idat[0]), .iwb_ack_o(iack[0]), .iwb_err_o(ierr[0]),
        .dwb_adr_i(dadr[0]), .dwb_dat_i(ddi[0]), .dwb_sel_i(dsel[0]), .dwb_we_i(dwe[0]),
        .dwb_cyc_i(dcyc[0]), .dwb_stb_i(dstb[0]),
        .dwb_dat_o(ddo[0]), .dwb_ack_o(dack[0]), .dwb_err_o(derr[0]));

    wb_dual_port_mem #(.DEPTH_WORDS(1024), .I_WAIT(2), .D_WAIT(3)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .iwb_adr_i(iadr[1]), .iwb_cyc_i(icyc[1]), .iwb_stb_i(istb[1]),
        .iwb_dat_o(idat[1]), .iwb_ack_o(iack[1]), .iwb_err_o(ierr[1]),
        .dwb_adr_i(dadr[1]), .dwb_dat_i(ddi[1]), .dwb_sel_i(dsel[1]), .dwb_we_i(dwe[1]),
        .dwb_cyc_i(dcyc[1]), .dwb_stb_i(dstb[1]),
        .dwb_dat_o(ddo[1]), .dwb_ack_o(dack[1]), .dwb_err_o(derr[1]));

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        chk;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t tv[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic d_access(input int k, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output logic [31:0] rd, output int lat, output logic er);
        @(posedge clk); #1;
        dadr[k] = adr; ddi[k] = dat; dsel[k] = sel; dwe[k] = we; dcyc[k] = 1'b1; dstb[k] = 1'b1;
        lat = 99; rd = '0; er = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (dack[k] || derr[k]) begin
                lat = c; rd = ddo[k]; er = derr[k];
                break;
            end
        end
        dcyc[k] = 1'b0; dstb[k] = 1'b0; dwe[k] = 1'b0;
    endtask

    task automatic i_access(input int k, input logic [31:0] adr, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        iadr[k] = adr; icyc[k] = 1'b1; istb[k] = 1'b1;
        lat = 99; rd = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (iack[k] || ierr[k]) begin
                lat = c; rd = idat[k];
                break;
            end
        end
        icyc[k] = 1'b0; istb[k] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, idata, ddata;
        int          lat, ilat, dlat, ipul, dpul, acks;
        logic        er;

        tv[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0};
        tv[1]  = '{1'b0, 32'h10,   32'h0,        4'hF, 1'b1, 32'hDEADBEEF, 1'b0};
        tv[2]  = '{1'b1, 32'h10,   32'h11223344, 4'h5, 1'b1, 32'hDEADBEEF, 1'b0};
        tv[3]  = '{1'b0, 32'h10,   32'h0,        4'hF, 1'b1, 32'hDE22BE44, 1'b0};
        tv[4]  = '{1'b0, 32'h13,   32'h0,        4'hF, 1'b1, 32'hDE22BE44, 1'b0};
        tv[5]  = '{1'b1, 32'h14,   32'hA5A5A5A5, 4'hF, 1'b0, 32'h0,        1'b0};
        tv[6]  = '{1'b1, 32'h14,   32'h00000000, 4'hA, 1'b1, 32'hA5A5A5A5, 1'b0};
        tv[7]  = '{1'b0, 32'h14,   32'h0,        4'hF, 1'b1, 32'h00A500A5, 1'b0};
        tv[8]  = '{1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        1'b0};
        tv[9]  = '{1'b0, 32'h1000, 32'h0,        4'hF, 1'b1, 32'hCAFEF00D, ERR};
        tv[10] = '{1'b1, 32'h1000, 32'h12345678, 4'h0, 1'b0, 32'h0,        ERR};
        tv[11] = '{1'b0, 32'h0,    32'h0,        4'hF, 1'b1, 32'hCAFEF00D, 1'b0};
        tv[12] = '{1'b1, 32'h20,   32'h00000013, 4'hF, 1'b0, 32'h0,        1'b0};

        for (int k = 0; k < 2; k++) begin
            iadr[k] = '0; icyc[k] = 1'b0; istb[k] = 1'b0;
            dadr[k] = '0; ddi[k] = '0; dsel[k] = '0; dwe[k] = 1'b0; dcyc[k] = 1'b0; dstb[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_idat%0d", k), idat[k], 32'h00000013);
            check($sformatf("reset_ddat%0d", k), ddo[k], 32'h0);
            check($sformatf("reset_acks%0d", k), {28'h0, iack[k], ierr[k], dack[k], derr[k]}, 32'h0);
        end

        for (int v = 0; v < 13; v++) begin
            d_access(0, tv[v].we, tv[v].adr, tv[v].dat, tv[v].sel, rd, lat, er);
            check($sformatf("vec%0d_lat", v), lat, 1);
            check($sformatf("vec%0d_err", v), {31'h0, er}, {31'h0, tv[v].err});
            if (tv[v].chk && !tv[v].err) check($sformatf("vec%0d_dat", v), rd, tv[v].exp);
        end

        @(posedge clk); #1;
        iadr[0] = 32'h20; icyc[0] = 1'b1; istb[0] = 1'b1;
        dadr[0] = 32'h20; ddi[0] = 32'hAA; dsel[0] = 4'hF; dwe[0] = 1'b1; dcyc[0] = 1'b1; dstb[0] = 1'b1;
        @(posedge clk); #1;
        check("coll_iack", {31'h0, iack[0]}, 32'h1);
        check("coll_dack", {31'h0, dack[0]}, 32'h1);
        check("coll_idat_old", idat[0], 32'h13);
        icyc[0] = 1'b0; istb[0] = 1'b0; dcyc[0] = 1'b0; dstb[0] = 1'b0; dwe[0] = 1'b0;
        i_access(0, 32'h20, rd, lat);
        check("coll_lat", lat, 1);
        check("coll_idat_new", rd, 32'hAA);

        d_access(1, 1'b1, 32'h40, 32'h12345678, 4'hF, rd, lat, er);
        check("w3_write_lat", lat, 4);

        @(posedge clk); #1;
        iadr[1] = 32'h40; icyc[1] = 1'b1; istb[1] = 1'b1;
        dadr[1] = 32'h40; dsel[1] = 4'hF; dwe[1] = 1'b0; dcyc[1] = 1'b1; dstb[1] = 1'b1;
        ilat = 0; dlat = 0; ipul = 0; dpul = 0; idata = '0; ddata = '0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (iack[1]) begin
                if (ilat == 0) ilat = c;
                ipul++; idata = idat[1]; icyc[1] = 1'b0; istb[1] = 1'b0;
            end
            if (dack[1]) begin
                if (dlat == 0) dlat = c;
                dpul++; ddata = ddo[1]; dcyc[1] = 1'b0; dstb[1] = 1'b0;
            end
        end
        check("conc_ilat", ilat, 3);
        check("conc_dlat", dlat, 4);
        check("conc_ipulses", ipul, 1);
        check("conc_dpulses", dpul, 1);
        check("conc_idat", idata, 32'h12345678);
        check("conc_ddat", ddata, 32'h12345678);

        @(posedge clk); #1;
        dadr[1] = 32'h40; ddi[1] = 32'hFFFFFFFF; dsel[1] = 4'hF; dwe[1] = 1'b1; dcyc[1] = 1'b1; dstb[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1 dcyc[1] = 1'b0; dstb[1] = 1'b0; dwe[1] = 1'b0;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (dack[1] || derr[1]) acks++;
        end
        check("abort_no_ack", acks, 0);
        d_access(1, 1'b0, 32'h40, 32'h0, 4'hF, rd, lat, er);
        check("abort_mem_kept", rd, 32'h12345678);

        @(posedge clk); #1;
        iadr[1] = 32'h40; icyc[1] = 1'b1; istb[1] = 1'b1;
        dadr[1] = 32'h40; ddi[1] = 32'h0; dsel[1] = 4'hF; dwe[1] = 1'b1; dcyc[1] = 1'b1; dstb[1] = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_iack", {31'h0, iack[1]}, 32'h0);
        check("rst_dack", {31'h0, dack[1]}, 32'h0);
        check("rst_idat", idat[1], 32'h00000013);
        check("rst_ddat", ddo[1], 32'h0);
        icyc[1] = 1'b0; istb[1] = 1'b0; dcyc[1] = 1'b0; dstb[1] = 1'b0; dwe[1] = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        d_access(1, 1'b0, 32'h40, 32'h0, 4'hF, rd, lat, er);
        check("rst_write_dropped", rd, 32'h12345678);
        check("rst_read_lat", lat, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
